// File: rtl/cic_pkg.sv
// Shared types and arithmetic for the CIC integrator chain.
//   ovf_mode_e : wrap (modulo) or saturate on accumulator overflow
//   sat_add    : width-generic add returning {ovf, sum}; operands live in the low
//                `width` bits of MaxWidth-bit vectors, upper bits are ignored.
package cic_pkg;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

  localparam int unsigned MaxWidth = 64;

  typedef struct packed {
    logic                ovf;
    logic [MaxWidth-1:0] sum;
  } add_res_t;

  function automatic add_res_t sat_add(input logic [MaxWidth-1:0] a,
                                       input logic [MaxWidth-1:0] b,
                                       input int unsigned         width,
                                       input logic                is_signed,
                                       input ovf_mode_e           mode);
    logic [MaxWidth:0]   full;
    logic [MaxWidth:0]   carry_sh;
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] msb;
    logic [MaxWidth-1:0] sum;
    logic                sa, sb, sr, ovf;
    add_res_t            res;
    mask     = {MaxWidth{1'b1}} >> (MaxWidth - width);
    msb      = {{(MaxWidth-1){1'b0}}, 1'b1} << (width - 1);
    full     = {1'b0, a & mask} + {1'b0, b & mask};
    carry_sh = full >> width;
    sum      = full[MaxWidth-1:0] & mask;
    sa       = |(a & msb);
    sb       = |(b & msb);
    sr       = |(sum & msb);
    ovf      = is_signed ? ((sa == sb) && (sr != sa)) : carry_sh[0];
    if (ovf && (mode == OVF_SAT)) begin
      if (!is_signed) begin
        sum = mask;
      end else if (sa) begin
        sum = msb;        // most negative
      end else begin
        sum = mask >> 1;  // most positive
      end
    end
    res.ovf = ovf;
    res.sum = sum;
    return res;
  endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One integrator stage: acc <= acc + x when en, plus the registered valid that
// enables the next stage.
//   clk, rstn : clock, asynchronous active-low reset
//   clear     : synchronous clear of accumulator and valid
//   en        : add x this edge
//   x         : addend (previous stage accumulator or extended input)
//   acc       : accumulator
//   vld       : en delayed by one edge (dropped by clear)
//   ovf       : combinational overflow pulse of the add taking effect this edge
module cic_int_stage
  import cic_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SIGNED   = 1'b0,
  parameter ovf_mode_e   OVF_MODE = OVF_WRAP
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] acc,
  output logic             vld,
  output logic             ovf
);

  logic [WIDTH-1:0] acc_d, acc_q;
  logic             vld_d, vld_q;
  add_res_t         add_res;

  always_comb begin
    add_res = sat_add(MaxWidth'(acc_q), MaxWidth'(x), WIDTH, SIGNED, OVF_MODE);
    acc_d   = acc_q;
    vld_d   = en & ~clear;
    ovf     = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = add_res.sum[WIDTH-1:0];
      ovf   = add_res.ovf;
    end
  end

  if (WIDTH < MaxWidth) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^add_res.sum[MaxWidth-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
    end
  end

  assign acc = acc_q;
  assign vld = vld_q;

endmodule

// File: rtl/cic_integrator_chain.sv
// Integrator section of a CIC decimator: N_STAGES cascaded integrators with a
// valid pipeline, synchronous clear, wrap/saturate arithmetic and sticky
// per-stage overflow flags.
//   clk, rstn  : clock, asynchronous active-low reset
//   din        : input sample (zero/sign-extended to WIDTH per SIGNED)
//   in_valid   : din valid this cycle
//   clear      : zero accumulators and valid pipe at next edge
//   ovf_clr    : clear sticky overflow flags (a same-edge overflow wins)
//   dout       : last-stage accumulator
//   out_valid  : dout updated by a valid beat this cycle
//   ovf_sticky : bit k set when stage k overflowed since last ovf_clr
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned N_STAGES = 3,
  parameter bit          SIGNED   = 1'b0,
  parameter ovf_mode_e   OVF_MODE = OVF_WRAP
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [IN_WIDTH-1:0] din,
  input  logic                in_valid,
  input  logic                clear,
  input  logic                ovf_clr,
  output logic [WIDTH-1:0]    dout,
  output logic                out_valid,
  output logic [N_STAGES-1:0] ovf_sticky
);

  logic [WIDTH-1:0]    din_ext;
  logic [WIDTH-1:0]    acc [N_STAGES];
  logic [N_STAGES-1:0] vld;
  logic [N_STAGES-1:0] ovf;
  logic [N_STAGES-1:0] sticky_d, sticky_q;

  if (WIDTH == IN_WIDTH) begin : g_ext_none
    assign din_ext = din;
  end else if (SIGNED) begin : g_ext_sign
    assign din_ext = {{(WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};
  end else begin : g_ext_zero
    assign din_ext = {{(WIDTH-IN_WIDTH){1'b0}}, din};
  end

  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] x;
    logic             en;
    if (k == 0) begin : g_first
      assign x  = din_ext;
      assign en = in_valid;
    end else begin : g_rest
      assign x  = acc[k-1];
      assign en = vld[k-1];
    end

    cic_int_stage #(
      .WIDTH    (WIDTH),
      .SIGNED   (SIGNED),
      .OVF_MODE (OVF_MODE)
    ) u_stage (
      .clk   (clk),
      .rstn  (rstn),
      .clear (clear),
      .en    (en),
      .x     (x),
      .acc   (acc[k]),
      .vld   (vld[k]),
      .ovf   (ovf[k])
    );
  end

  // New overflows are OR-ed in after the clear so a coincident overflow wins.
  always_comb begin
    sticky_d = (ovf_clr ? '0 : sticky_q) | ovf;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign dout       = acc[N_STAGES-1];
  assign out_valid  = vld[N_STAGES-1];
  assign ovf_sticky = sticky_q;

endmodule
